// File: rtl/vedic_mac_seq.sv
// vedic_mac_seq: sequential Urdhva-Tiryagbhyam multiplier / multiply-accumulate.
// WIDTH-bit unsigned operands are split into 4-bit digits. One digit pair is
// multiplied per cycle by a single shared 4x4 Vedic core. The shifted partial
// product is added into a working sum that is one bit wider than the
// accumulator, and that extra bit becomes the per-operation overflow flag.
module vedic_mac_seq #(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_mac,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+GUARD-1:0]   out_result,
    output logic                       out_ovf
);

    localparam int ACC_W = 2 * WIDTH + GUARD;
    localparam int D     = WIDTH / 4;
    localparam int DW    = (D > 1) ? $clog2(D) : 1;

    localparam logic [DW-1:0] LAST_DIG = DW'(D - 1);
    localparam logic [DW-1:0] ONE_DIG  = DW'(1'b1);
    localparam logic [DW-1:0] ZERO_DIG = {DW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 4x4 Urdhva-Tiryagbhyam core: vertical-and-crosswise column sums with
    // ripple of the column carries, giving the 8-bit digit product.
    function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] col;
        logic [3:0] carry;
        logic [4:0] s;
        logic [7:0] p;
        carry = 4'd0;
        p     = 8'd0;
        for (int n = 0; n < 7; n++) begin
            col = 4'd0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (i + j == n) begin
                        col = col + {3'b000, a[i] & b[j]};
                    end else begin
                        col = col;
                    end
                end
            end
            s     = {1'b0, col} + {1'b0, carry};
            p[n]  = s[0];
            carry = s[4:1];
        end
        p[7] = carry[0];
        return p;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [DW-1:0]      i_q, i_d;       // multiplicand digit index (k % D)
    logic [DW-1:0]      j_q, j_d;       // multiplier digit index   (k / D)
    logic [ACC_W:0]     sum_q, sum_d;   // MSB catches the carry out of ACC_W
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         a_dig_s;
    logic [3:0]         b_dig_s;
    logic [7:0]         pp_s;
    logic [DW:0]        dsum_s;
    logic [ACC_W:0]     pp_shift_s;

    // Current digit pair, its product from the shared core, and its weight 16^(i+j).
    assign a_dig_s    = 4'(a_q >> {i_q, 2'b00});
    assign b_dig_s    = 4'(b_q >> {j_q, 2'b00});
    assign pp_s       = vedic4x4(a_dig_s, b_dig_s);
    assign dsum_s     = {1'b0, i_q} + {1'b0, j_q};
    assign pp_shift_s = {{(ACC_W + 1 - 8){1'b0}}, pp_s} << {dsum_s, 2'b00};

    // Handshake flags are decoded from the state register only.
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_ovf    = ovf_q;

    // Next-state and datapath update: accept, digit-pair accumulation, handoff.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        i_d      = i_q;
        j_d      = j_q;
        sum_d    = sum_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    a_d     = in_a;
                    b_d     = in_b;
                    i_d     = ZERO_DIG;
                    j_d     = ZERO_DIG;
                    sum_d   = in_mac ? {1'b0, result_q} : {(ACC_W + 1){1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                sum_d = sum_q + pp_shift_s;
                if ((i_q == LAST_DIG) && (j_q == LAST_DIG)) begin
                    state_d  = S_DONE;
                    result_d = sum_d[ACC_W-1:0];
                    ovf_d    = sum_d[ACC_W];
                end else if (i_q == LAST_DIG) begin
                    i_d = ZERO_DIG;
                    j_d = j_q + ONE_DIG;
                end else begin
                    i_d = i_q + ONE_DIG;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            i_q      <= ZERO_DIG;
            j_q      <= ZERO_DIG;
            sum_q    <= {(ACC_W + 1){1'b0}};
            result_q <= {ACC_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            j_q      <= j_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vedic_mac_seq.sv
// Self-checking bench for vedic_mac_seq: WIDTH=8, 4 and 16 instances, directed
// cases plus randomized operations against an arithmetic reference model.
module tb_vedic_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv8, ir8, im8, ov8, or8, ovf8;
    logic [7:0]  a8, b8;
    logic [19:0] r8;

    logic        iv4, ir4, im4, ov4, or4, ovf4;
    logic [3:0]  a4, b4;
    logic [11:0] r4;

    logic        iv16, ir16, im16, ov16, or16, ovf16;
    logic [15:0] a16, b16;
    logic [35:0] r16;

    vedic_mac_seq #(.WIDTH(8), .GUARD(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_mac(im8), .out_valid(ov8), .out_ready(or8), .out_result(r8), .out_ovf(ovf8));

    vedic_mac_seq #(.WIDTH(4), .GUARD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_mac(im4), .out_valid(ov4), .out_ready(or4), .out_result(r4), .out_ovf(ovf4));

    vedic_mac_seq #(.WIDTH(16), .GUARD(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_mac(im16), .out_valid(ov16), .out_ready(or16), .out_result(r16), .out_ovf(ovf16));

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned acc_m [3];   // reference accumulator per instance

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int acc_w(input int sel);
        case (sel)
            0: return 20;
            1: return 12;
            default: return 36;
        endcase
    endfunction

    function automatic int latency(input int sel);
        case (sel)
            0: return 4;
            1: return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] op_mask(input int sel);
        case (sel)
            0: return 16'h00ff;
            1: return 16'h000f;
            default: return 16'hffff;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return ir8;
            1: return ir4;
            default: return ir16;
        endcase
    endfunction

    function automatic logic get_valid(input int sel);
        case (sel)
            0: return ov8;
            1: return ov4;
            default: return ov16;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0: return ovf8;
            1: return ovf4;
            default: return ovf16;
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int sel);
        case (sel)
            0: return {44'd0, r8};
            1: return {52'd0, r4};
            default: return {28'd0, r16};
        endcase
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic mac);
        case (sel)
            0: begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; im8 = mac; end
            1: begin iv4 = v; a4 = a[3:0]; b4 = b[3:0]; im4 = mac; end
            default: begin iv16 = v; a16 = a; b16 = b; im16 = mac; end
        endcase
    endtask

    task automatic set_oready(input int sel, input logic v);
        case (sel)
            0: or8 = v;
            1: or4 = v;
            default: or16 = v;
        endcase
    endtask

    // Reference: result = ((mac ? prev : 0) + a*b) mod 2^ACC_W, ovf = carry out.
    task automatic model_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                            input logic mac, output logic [63:0] exp_r, output logic exp_o);
        longint unsigned full;
        longint unsigned prod;
        prod  = longint'({48'd0, a}) * longint'({48'd0, b});
        full  = (mac ? acc_m[sel] : 64'd0) + prod;
        exp_r = full & ((64'd1 << acc_w(sel)) - 64'd1);
        exp_o = (full >> acc_w(sel)) != 64'd0;
        acc_m[sel] = exp_r;
    endtask

    task automatic wait_valid(input int sel, input string tag, input logic [63:0] exp_r,
                              input logic exp_o);
        int cyc;
        cyc = 0;
        while (!get_valid(sel) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check_val({tag, "_lat"}, cyc, latency(sel));
        check_val({tag, "_res"}, get_res(sel), exp_r);
        check_val({tag, "_ovf"}, get_ovf(sel), exp_o);
    endtask

    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic mac, input string tag);
        int cyc;
        logic [63:0] exp_r;
        logic        exp_o;
        cyc = 0;
        while (!get_ready(sel) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check_val({tag, "_rdy"}, get_ready(sel), 1);
        drive_in(sel, 1'b1, a, b, mac);
        @(posedge clk); #1;
        // Scrambled operands while busy must not disturb the operation.
        drive_in(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        model_op(sel, a, b, mac, exp_r, exp_o);
        wait_valid(sel, tag, exp_r, exp_o);
        set_oready(sel, 1'b1);
        @(posedge clk); #1;
        set_oready(sel, 1'b0);
        check_val({tag, "_vld_clr"}, get_valid(sel), 0);
        check_val({tag, "_rdy_back"}, get_ready(sel), 1);
    endtask

    initial begin
        logic [63:0] exp_r;
        logic        exp_o;
        logic [19:0] held;
        int          cyc;
        int          seen;

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 16'd0, 16'd0, 1'b0);
            set_oready(s, 1'b0);
            acc_m[s] = 64'd0;
        end
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_in_ready", ir8, 1);
        check_val("rst_out_valid", ov8, 0);
        check_val("rst_out_result", r8, 0);
        check_val("rst_out_ovf", ovf8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed WIDTH=8 cases.
        do_op(0, 16'd3, 16'd2, 1'b0, "m3x2");
        check_val("m3x2_const", r8, 6);
        do_op(0, 16'd255, 16'd255, 1'b0, "m255sq");
        check_val("m255sq_const", r8, 65025);
        do_op(0, 16'd200, 16'd100, 1'b0, "m200x100");
        check_val("m200x100_const", r8, 20000);
        do_op(0, 16'd10, 16'd10, 1'b1, "mac10x10");
        check_val("mac10x10_const", r8, 20100);

        // Accumulator wrap and overflow flag.
        do_op(0, 16'd0, 16'd0, 1'b0, "clr");
        for (int n = 0; n < 16; n++) begin
            do_op(0, 16'd255, 16'd255, 1'b1, "acc");
        end
        check_val("acc16_res", r8, 1040400);
        check_val("acc16_ovf", ovf8, 0);
        do_op(0, 16'd255, 16'd255, 1'b1, "acc17");
        check_val("acc17_res", r8, 56849);
        check_val("acc17_ovf", ovf8, 1);
        do_op(0, 16'd0, 16'd9, 1'b0, "m0x9");
        check_val("m0x9_res", r8, 0);
        check_val("m0x9_ovf", ovf8, 0);

        // Backpressure with a new operand set waiting on in_valid.
        drive_in(0, 1'b1, 16'd7, 16'd9, 1'b0);
        @(posedge clk); #1;
        model_op(0, 16'd7, 16'd9, 1'b0, exp_r, exp_o);
        drive_in(0, 1'b1, 16'd11, 16'd13, 1'b1);
        wait_valid(0, "bp_first", exp_r, exp_o);
        held = r8;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            check_val("bp_valid_hold", ov8, 1);
            check_val("bp_result_hold", r8, held);
            check_val("bp_in_ready_low", ir8, 0);
        end
        set_oready(0, 1'b1);
        @(posedge clk); #1;
        set_oready(0, 1'b0);
        check_val("bp_release_ready", ir8, 1);
        check_val("bp_release_valid", ov8, 0);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 16'd0, 16'd0, 1'b0);
        check_val("bp_accept_busy", ir8, 0);
        model_op(0, 16'd11, 16'd13, 1'b1, exp_r, exp_o);
        wait_valid(0, "bp_second", exp_r, exp_o);
        check_val("bp_second_const", r8, 206);
        set_oready(0, 1'b1);
        @(posedge clk); #1;
        set_oready(0, 1'b0);

        // Reset in the middle of an operation.
        drive_in(0, 1'b1, 16'd5, 16'd4, 1'b0);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 16'd0, 16'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", ov8, 0);
        check_val("mrst_result", r8, 0);
        check_val("mrst_ovf", ovf8, 0);
        check_val("mrst_ready", ir8, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) acc_m[s] = 64'd0;
        seen = 0;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        check_val("mrst_no_result", seen, 0);
        do_op(0, 16'd5, 16'd4, 1'b0, "mrst_redo");
        check_val("mrst_redo_const", r8, 20);

        // WIDTH=4 and WIDTH=16 instances.
        do_op(1, 16'd15, 16'd15, 1'b0, "w4_15sq");
        check_val("w4_15sq_const", r4, 225);
        do_op(2, 16'hffff, 16'hffff, 1'b0, "w16_max");
        check_val("w16_max_const", r16, 36'd4294836225);

        // Randomized operations across all instances.
        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic [15:0] ra;
            logic [15:0] rb;
            sel = int'($urandom_range(0, 2));
            ra  = 16'($urandom) & op_mask(sel);
            rb  = 16'($urandom) & op_mask(sel);
            do_op(sel, ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
